// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RISC-V sequencer: opcodes, FSM states,
// instruction classes and ALU operation classes.
package ctrl_pkg;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;

  typedef enum logic [2:0] {
    StFetch  = 3'b000,
    StDecode = 3'b001,
    StExec   = 3'b010,
    StMem    = 3'b011,
    StWb     = 3'b100,
    StTrap   = 3'b101
  } state_e;

  typedef enum logic [2:0] {
    ClsR       = 3'd0,
    ClsI       = 3'd1,
    ClsLoad    = 3'd2,
    ClsStore   = 3'd3,
    ClsBranch  = 3'd4,
    ClsIllegal = 3'd5
  } cls_e;

  localparam logic [1:0] AluAdd   = 2'b00;
  localparam logic [1:0] AluSub   = 2'b01;
  localparam logic [1:0] AluRType = 2'b10;
  localparam logic [1:0] AluIType = 2'b11;

  function automatic cls_e decode_class(input logic [6:0] op);
    cls_e cls;
    case (op)
      OpR:      cls = ClsR;
      OpI:      cls = ClsI;
      OpLoad:   cls = ClsLoad;
      OpStore:  cls = ClsStore;
      OpBranch: cls = ClsBranch;
      default:  cls = ClsIllegal;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles a memory request has been waiting for ready; flags the cycle in
// which one more wait would exceed the allowed limit.
module mem_wait_timer #(
  parameter int unsigned MemTimeout = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic waiting_i,
  output logic timeout_o
);

  localparam int unsigned CntW = (MemTimeout > 1) ? $clog2(MemTimeout) : 1;
  localparam logic [CntW-1:0] Last = CntW'(MemTimeout - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (waiting_i) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_o = waiting_i && (cnt_q == Last);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer: walks each instruction through FETCH/DECODE/EXEC/MEM/WB,
// drives datapath controls and memory handshakes, traps and counts retirements.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             alu_zero,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             dmem_req,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             trap,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] retired_count
);

  state_e           state_q, state_d;
  cls_e             cls_q, cls_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;
  logic             waiting;
  logic             timeout;
  logic             wait_clear;

  assign waiting = ((state_q == StFetch) && !imem_ready) || ((state_q == StMem) && !dmem_ready);
  // Any state change restarts the count, which covers every entry into FETCH or MEM.
  assign wait_clear = (state_d != state_q);

  mem_wait_timer #(
    .MemTimeout(MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clk_i    (clk),
    .rst_i    (rst),
    .clear_i  (wait_clear),
    .waiting_i(waiting),
    .timeout_o(timeout)
  );

  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    retire     = 1'b0;
    imem_req   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    alu_src    = 1'b0;
    alu_op     = AluAdd;
    dmem_req   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    trap       = 1'b0;
    // Controls stay low for as long as reset is held, even though state reads FETCH.
    if (!rst) begin
      unique case (state_q)
        StFetch: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = StDecode;
          end else if (timeout) begin
            state_d = StTrap;
          end
        end
        StDecode: begin
          cls_d   = decode_class(opcode);
          state_d = (cls_d == ClsIllegal) ? StTrap : StExec;
        end
        StExec: begin
          unique case (cls_q)
            ClsR: begin
              alu_op  = AluRType;
              state_d = StWb;
            end
            ClsI: begin
              alu_src = 1'b1;
              alu_op  = AluIType;
              state_d = StWb;
            end
            ClsLoad, ClsStore: begin
              alu_src = 1'b1;
              state_d = StMem;
            end
            ClsBranch: begin
              alu_op   = AluSub;
              pc_src   = 1'b1;
              pc_write = alu_zero;
              retire   = 1'b1;
              state_d  = StFetch;
            end
            default: state_d = StTrap;
          endcase
        end
        StMem: begin
          dmem_req  = 1'b1;
          mem_read  = (cls_q == ClsLoad);
          mem_write = (cls_q == ClsStore);
          if (dmem_ready) begin
            if (cls_q == ClsLoad) begin
              state_d = StWb;
            end else begin
              retire  = 1'b1;
              state_d = StFetch;
            end
          end else if (timeout) begin
            state_d = StTrap;
          end
        end
        StWb: begin
          reg_write  = 1'b1;
          mem_to_reg = (cls_q == ClsLoad);
          retire     = 1'b1;
          state_d    = StFetch;
        end
        StTrap: trap = 1'b1;
        default: state_d = StTrap;
      endcase
    end
  end

  assign cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFetch;
      cls_q   <= ClsR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state_o       = state_q;
  assign retired_count = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected control vectors are
// queued as stimulus is driven and popped when the outputs are sampled.
module tb_multicycle_ctrl;

  localparam int unsigned CntW = 4;

  logic            clk;
  logic            rst;
  logic [6:0]      opcode;
  logic            alu_zero;
  logic            imem_ready;
  logic            dmem_ready;
  logic            imem_req, ir_write, pc_write, pc_src, alu_src;
  logic [1:0]      alu_op;
  logic            dmem_req, mem_read, mem_write, mem_to_reg, reg_write, trap;
  logic [2:0]      state_o;
  logic [CntW-1:0] retired_count;

  multicycle_ctrl #(
    .MEM_TIMEOUT(4),
    .CNT_W      (CntW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .alu_zero     (alu_zero),
    .imem_ready   (imem_ready),
    .dmem_ready   (dmem_ready),
    .imem_req     (imem_req),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .alu_src      (alu_src),
    .alu_op       (alu_op),
    .dmem_req     (dmem_req),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_to_reg   (mem_to_reg),
    .reg_write    (reg_write),
    .trap         (trap),
    .state_o      (state_o),
    .retired_count(retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {imem_req, ir_write, pc_write, pc_src, alu_src, alu_op, dmem_req, mem_read,
  //  mem_write, mem_to_reg, reg_write, trap, state}
  logic [15:0] obs;
  assign obs = {imem_req, ir_write, pc_write, pc_src, alu_src, alu_op, dmem_req, mem_read,
                mem_write, mem_to_reg, reg_write, trap, state_o};

  localparam logic [15:0] Zero   = 16'b0_0_0_0_0_00_0_0_0_0_0_0_000;
  localparam logic [15:0] FWait  = 16'b1_0_0_0_0_00_0_0_0_0_0_0_000;
  localparam logic [15:0] FRdy   = 16'b1_1_1_0_0_00_0_0_0_0_0_0_000;
  localparam logic [15:0] Dec    = 16'b0_0_0_0_0_00_0_0_0_0_0_0_001;
  localparam logic [15:0] ExR    = 16'b0_0_0_0_0_10_0_0_0_0_0_0_010;
  localparam logic [15:0] ExI    = 16'b0_0_0_0_1_11_0_0_0_0_0_0_010;
  localparam logic [15:0] ExLs   = 16'b0_0_0_0_1_00_0_0_0_0_0_0_010;
  localparam logic [15:0] ExBz   = 16'b0_0_1_1_0_01_0_0_0_0_0_0_010;
  localparam logic [15:0] ExBnz  = 16'b0_0_0_1_0_01_0_0_0_0_0_0_010;
  localparam logic [15:0] MemLd  = 16'b0_0_0_0_0_00_1_1_0_0_0_0_011;
  localparam logic [15:0] MemSt  = 16'b0_0_0_0_0_00_1_0_1_0_0_0_011;
  localparam logic [15:0] WbR    = 16'b0_0_0_0_0_00_0_0_0_0_1_0_100;
  localparam logic [15:0] WbLd   = 16'b0_0_0_0_0_00_0_0_0_1_1_0_100;
  localparam logic [15:0] Trap   = 16'b0_0_0_0_0_00_0_0_0_0_0_1_101;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] Junk     = 7'b1111111;

  string           tag_q[$];
  logic [15:0]     exp_q[$];
  logic [CntW-1:0] exp_cnt;
  int              n_vec;
  int              n_err;

  task automatic check_out();
    string       tag;
    logic [15:0] exp;
    tag = tag_q.pop_front();
    exp = exp_q.pop_front();
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s ctrl: observed %b expected %b", tag, obs, exp);
    end
    n_vec++;
    assert (retired_count === exp_cnt) else begin
      n_err++;
      $error("FAIL %s count: observed %0d expected %0d", tag, retired_count, exp_cnt);
    end
  endtask

  // One clock cycle: drive inputs just after the falling edge, sample 1ns later.
  task automatic cyc(input string tag, input logic [6:0] op, input logic ir, input logic dr,
                     input logic az, input logic [15:0] exp);
    opcode     = op;
    imem_ready = ir;
    dmem_ready = dr;
    alu_zero   = az;
    tag_q.push_back(tag);
    exp_q.push_back(exp);
    #1;
    check_out();
    @(negedge clk);
  endtask

  task automatic reset_pulse(input string tag);
    rst     = 1'b1;
    exp_cnt = '0;
    tag_q.push_back(tag);
    exp_q.push_back(Zero);
    #1;
    check_out();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic fetch_decode(input string tag, input logic [6:0] op);
    cyc({tag, "_fetch"}, Junk, 1'b1, 1'b0, 1'b0, FRdy);
    cyc({tag, "_decode"}, op, 1'b0, 1'b0, 1'b0, Dec);
  endtask

  task automatic run_r(input string tag);
    fetch_decode(tag, OpR);
    cyc({tag, "_exec"}, Junk, 1'b0, 1'b0, 1'b0, ExR);
    cyc({tag, "_wb"}, Junk, 1'b0, 1'b0, 1'b0, WbR);
    exp_cnt++;
  endtask

  task automatic run_branch(input string tag, input logic az);
    fetch_decode(tag, OpBranch);
    cyc({tag, "_exec"}, Junk, 1'b0, 1'b0, az, az ? ExBz : ExBnz);
    exp_cnt++;
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    exp_cnt    = '0;
    rst        = 1'b1;
    opcode     = OpR;
    alu_zero   = 1'b0;
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    @(negedge clk);
    reset_pulse("reset");

    run_r("rtype");

    fetch_decode("itype", OpI);
    cyc("itype_exec", Junk, 1'b0, 1'b0, 1'b0, ExI);
    cyc("itype_wb", Junk, 1'b0, 1'b0, 1'b0, WbR);
    exp_cnt++;

    fetch_decode("load", OpLoad);
    cyc("load_exec", Junk, 1'b0, 1'b0, 1'b0, ExLs);
    cyc("load_mem0", Junk, 1'b0, 1'b0, 1'b0, MemLd);
    cyc("load_mem1", Junk, 1'b0, 1'b0, 1'b0, MemLd);
    cyc("load_mem2", Junk, 1'b0, 1'b1, 1'b0, MemLd);
    cyc("load_wb", Junk, 1'b0, 1'b0, 1'b0, WbLd);
    exp_cnt++;

    fetch_decode("store", OpStore);
    cyc("store_exec", Junk, 1'b0, 1'b0, 1'b0, ExLs);
    cyc("store_mem", Junk, 1'b0, 1'b1, 1'b0, MemSt);
    exp_cnt++;

    run_branch("br_taken", 1'b1);
    run_branch("br_not_taken", 1'b0);

    // Instruction ready on the last allowed fetch cycle.
    for (int i = 0; i < 3; i++) cyc("late_fetch_wait", Junk, 1'b0, 1'b0, 1'b0, FWait);
    run_r("late_fetch");

    // Data ready on the last allowed memory cycle.
    fetch_decode("late_store", OpStore);
    cyc("late_store_exec", Junk, 1'b0, 1'b0, 1'b0, ExLs);
    for (int i = 0; i < 3; i++) cyc("late_store_wait", Junk, 1'b0, 1'b0, 1'b0, MemSt);
    cyc("late_store_rdy", Junk, 1'b0, 1'b1, 1'b0, MemSt);
    exp_cnt++;

    // Eight more retirements bring the 4-bit count to 16, i.e. back to 0.
    for (int i = 0; i < 8; i++) run_branch("wrap", i[0]);
    run_r("post_wrap");

    fetch_decode("illegal", Junk);
    for (int i = 0; i < 22; i++) cyc("trap_hold", OpR, 1'b1, 1'b1, i[0], Trap);
    reset_pulse("trap_reset");

    for (int i = 0; i < 4; i++) cyc("imem_to_wait", Junk, 1'b0, 1'b0, 1'b0, FWait);
    cyc("imem_to_trap", Junk, 1'b1, 1'b1, 1'b0, Trap);
    cyc("imem_to_trap2", Junk, 1'b1, 1'b1, 1'b0, Trap);
    reset_pulse("imem_to_reset");

    fetch_decode("dmem_to", OpLoad);
    cyc("dmem_to_exec", Junk, 1'b0, 1'b0, 1'b0, ExLs);
    for (int i = 0; i < 4; i++) cyc("dmem_to_wait", Junk, 1'b0, 1'b0, 1'b0, MemLd);
    cyc("dmem_to_trap", Junk, 1'b1, 1'b1, 1'b0, Trap);
    reset_pulse("dmem_to_reset");

    run_r("pre_abort");
    fetch_decode("abort", OpStore);
    cyc("abort_exec", Junk, 1'b0, 1'b0, 1'b0, ExLs);
    cyc("abort_wait0", Junk, 1'b0, 1'b0, 1'b0, MemSt);
    cyc("abort_wait1", Junk, 1'b0, 1'b0, 1'b0, MemSt);
    reset_pulse("abort_reset");
    cyc("after_abort", Junk, 1'b0, 1'b0, 1'b0, FWait);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
